// File: rtl/error_event_collector.sv
// Collects per-source checker failures: saturating event count, first-failing source,
// and a round-robin arbitrated FIFO of failing source IDs with overrun detection.
module error_event_collector #(
  parameter int N_SRC = 4,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] fail,
  input  logic             clr,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [IW-1:0]    err_id,
  output logic [CNT_W-1:0] err_count,
  output logic             first_valid,
  output logic [IW-1:0]    first_id,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [N_SRC-1:0] pending_reg;
  logic [IW-1:0]    rr_ptr_reg;
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [IW-1:0]    fifo_mem [DEPTH];
  logic [CNT_W-1:0] count_reg;
  logic             first_valid_reg;
  logic [IW-1:0]    first_id_reg;
  logic             overrun_reg;

  logic             fifo_empty, fifo_full, pop, can_push;
  logic             grant_valid;
  logic [IW-1:0]    grant_id;
  logic [N_SRC-1:0] grant_oh;
  logic [IW-1:0]    low_id;
  logic [IW:0]      pop_cnt;
  logic [CNT_W:0]   sum_w;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && err_ready;
  // A full FIFO can still accept a grant when its head leaves in the same cycle.
  assign can_push   = !fifo_full || pop;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_oh    = '0;
    if (can_push) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (!grant_valid && pending_reg[(int'(rr_ptr_reg) + k) % N_SRC]) begin
          grant_valid = 1'b1;
          grant_id    = IW'((int'(rr_ptr_reg) + k) % N_SRC);
        end
      end
    end
    grant_oh[grant_id] = grant_valid;
  end

  always_comb begin
    low_id  = '0;
    pop_cnt = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (fail[k]) low_id = IW'(k);
    end
    for (int k = 0; k < N_SRC; k++) begin
      pop_cnt = pop_cnt + (IW + 1)'(fail[k]);
    end
    // The carry bit flags any sum beyond the counter range, since popcount is small.
    sum_w = {1'b0, count_reg} + (CNT_W + 1)'(pop_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg     <= '0;
      rr_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      first_valid_reg <= 1'b0;
      first_id_reg    <= '0;
      overrun_reg     <= 1'b0;
    end else if (clr) begin
      pending_reg     <= '0;
      rr_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      first_valid_reg <= 1'b0;
      first_id_reg    <= '0;
      overrun_reg     <= 1'b0;
    end else begin
      pending_reg <= (pending_reg & ~grant_oh) | fail;
      if (|(fail & pending_reg & ~grant_oh)) overrun_reg <= 1'b1;
      count_reg <= sum_w[CNT_W] ? {CNT_W{1'b1}} : sum_w[CNT_W-1:0];
      if (!first_valid_reg && (|fail)) begin
        first_valid_reg <= 1'b1;
        first_id_reg    <= low_id;
      end
      if (grant_valid) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (int'(grant_id) == N_SRC - 1) rr_ptr_reg <= '0;
        else                             rr_ptr_reg <= grant_id + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_valid && !clr) fifo_mem[wr_ptr_reg[AW-1:0]] <= grant_id;
  end

  assign err_valid   = !fifo_empty;
  assign err_id      = fifo_empty ? '0 : fifo_mem[rd_ptr_reg[AW-1:0]];
  assign err_count   = count_reg;
  assign first_valid = first_valid_reg;
  assign first_id    = first_id_reg;
  assign overrun     = overrun_reg;

endmodule
